acc_feeder: RTL and testbench
=============================

ACC_FEEDER -- requirements
Module: acc_feeder

Interface
REQ-001 Parameter: W, 8, data width of samples and accumulator input.
REQ-002 Parameter: DEPTH, 4, FIFO entries; power of two, >=2.
REQ-003 clk  input  1  sole clock; all state on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 s_valid  input  1  producer offers s_data.
REQ-006 s_data  input  W  sample from producer.
REQ-007 s_ready  output  1  feeder can accept a sample this cycle.
REQ-008 hold  input  1  stall draining toward accumulator.
REQ-009 acc_in  output  W  sample driven to accumulator data input.
REQ-010 acc_ce  output  1  accumulator clock enable; one pulse per sample.
REQ-011 level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 issued_cnt  output  16  samples delivered to accumulator, wrapping.

Function
REQ-013 Push SHALL occur on a posedge with s_valid=1 and s_ready=1; s_data written at write pointer.
REQ-014 s_ready SHALL equal (level != DEPTH), combinational from registered level; no bypass when full.
REQ-015 Pop SHALL occur on a posedge with level != 0 and hold=0; head entry read at read pointer.
REQ-016 On pop: acc_in <= head, acc_ce <= 1 at that edge; otherwise acc_ce <= 0 and acc_in holds its last value.
REQ-017 Latency: sample pushed at edge N into an empty FIFO with hold=0 SHALL appear with acc_ce=1 after edge N+1.
REQ-018 Throughput: with continuous s_valid and hold=0, one acc_ce pulse per cycle, order preserved.
REQ-019 Simultaneous push and pop: level unchanged; both pointers advance.
REQ-020 Read/write pointers SHALL wrap modulo DEPTH.
REQ-021 Empty (level=0): no pop, acc_ce=0 regardless of hold.
REQ-022 Full (level=DEPTH): s_ready=0; s_valid ignored, s_data not written.
REQ-023 hold=1 SHALL block pop only; pushes continue until full.
REQ-024 issued_cnt SHALL increment by 1 on each pop, wrapping 0xFFFF -> 0x0000.
REQ-025 Outputs change only on posedge clk or on reset assertion.

Reset
REQ-026 rst=0 SHALL immediately clear: pointers=0, level=0, acc_in=0, acc_ce=0, issued_cnt=0; s_ready=1 follows.
REQ-027 Reset mid-operation SHALL discard all buffered samples; no acc_ce pulse from pre-reset data after release.
REQ-028 FIFO storage array need not be reset.
REQ-029 First push accepted on first posedge after rst returns high.

Configuration
REQ-030 Macro ACC_FEEDER_FLUSH_EN, when defined, SHALL add input port flush (1 bit).
REQ-031 With macro: flush=1 at posedge sets pointers=0, level=0, acc_ce=0; overrides push and pop that cycle; acc_in and issued_cnt unchanged; s_ready=0 while flush=1.
REQ-032 Without macro: no flush port; FIFO cleared only by reset.

Verification
REQ-033 Reset then push 0x11 at edge 1, hold=0 -> acc_ce=1, acc_in=0x11 after edge 2; level back to 0.
REQ-034 hold=1, push 0x01..0x05 on 5 consecutive cycles -> 4 accepted, s_ready=0 at level 4, 0x05 rejected; release hold -> acc_in 0x01,0x02,0x03,0x04 on consecutive cycles.
REQ-035 Continuous stream 0x00..0x0F, hold=0 -> 16 consecutive acc_ce pulses in order, level<=1, issued_cnt=16.
REQ-036 Fill 3 entries, assert rst=0 mid-cycle -> acc_ce=0, level=0 immediately; after release no stale data emitted.
REQ-037 Preload issued_cnt to 0xFFFF via 65535 pops, one more pop -> issued_cnt=0x0000.
REQ-038 With ACC_FEEDER_FLUSH_EN: level=3, flush=1 with s_valid=1 -> level=0 next edge, no pop, sample not stored.

Source files
------------

// File: rtl/acc_feeder.sv
// Sample FIFO feeding an accumulator: one acc_ce pulse per delivered sample.
// Optional ACC_FEEDER_FLUSH_EN adds a synchronous flush input.
module acc_feeder #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef ACC_FEEDER_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     s_valid,
  input  logic [W-1:0]             s_data,
  output logic                     s_ready,
  input  logic                     hold,
  output logic [W-1:0]             acc_in,
  output logic                     acc_ce,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              issued_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [LW-1:0] LVL_ZERO  = LW'(0);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

  logic [W-1:0]    mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [LW-1:0]   level_r;
  logic [W-1:0]    acc_in_r;
  logic            acc_ce_r;
  logic [15:0]     issued_cnt_r;

  logic            flush_s;
  logic            full_s;
  logic            push_s;
  logic            pop_s;

`ifdef ACC_FEEDER_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Handshake decode; flush blocks both directions for the cycle.
  always_comb begin
    full_s = (level_r == LVL_FULL);
    if (flush_s) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      push_s = s_valid && !full_s;
      pop_s  = (level_r != LVL_ZERO) && !hold;
    end
  end

  assign s_ready    = !full_s && !flush_s;
  assign acc_in     = acc_in_r;
  assign acc_ce     = acc_ce_r;
  assign level      = level_r;
  assign issued_cnt = issued_cnt_r;

  // Sample storage, intentionally not reset; level gates all reads.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s_data;
    end
  end

  // Pointers, occupancy and accumulator-side registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      level_r      <= '0;
      acc_in_r     <= '0;
      acc_ce_r     <= 1'b0;
      issued_cnt_r <= 16'd0;
    end else if (flush_s) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      acc_ce_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r     <= rd_ptr_r + PTR_ONE;
        acc_in_r     <= mem_r[rd_ptr_r];
        acc_ce_r     <= 1'b1;
        issued_cnt_r <= issued_cnt_r + 16'd1;
      end else begin
        acc_ce_r <= 1'b0;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_feeder.sv
// Directed bench for acc_feeder with a queue scoreboard of accepted samples.
module tb_acc_feeder;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        hold;
  logic [7:0]  acc_in;
  logic        acc_ce;
  logic [2:0]  level;
  logic [15:0] issued_cnt;
`ifdef ACC_FEEDER_FLUSH_EN
  logic        flush;
`endif
  logic        fl;

  int          passed;
  int          total;
  int          pulses;
  logic [7:0]  mq[$];
  logic [7:0]  macc;
  logic [15:0] mcnt;

  acc_feeder #(.W(8), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef ACC_FEEDER_FLUSH_EN
    .flush      (flush),
`endif
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .hold       (hold),
    .acc_in     (acc_in),
    .acc_ce     (acc_ce),
    .level      (level),
    .issued_cnt (issued_cnt)
  );

`ifdef ACC_FEEDER_FLUSH_EN
  assign flush = fl;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    macc = 8'h00;
    mcnt = 16'h0000;
  endtask

  // Reset asserted between edges; checks the immediate clear.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_acc_ce", acc_ce, 1'b0);
    check("rst_level", level, 3'd0);
    check("rst_acc_in", acc_in, 8'h00);
    check("rst_issued", issued_cnt, 16'h0000);
    check("rst_s_ready", s_ready, 1'b1);
    #1;
    rst = 1'b1;
  endtask

  // One clock: drive, predict, clock, compare against scoreboard.
  task automatic cyc(input bit v, input logic [7:0] d, input bit h, input bit chk);
    bit exp_ready, exp_pop, exp_push;
    logic [7:0] expd;
    s_valid = v;
    s_data  = d;
    hold    = h;
    #1;
    exp_ready = (mq.size() != DEPTH) && !fl;
    exp_pop   = (mq.size() != 0) && !h && !fl;
    exp_push  = v && exp_ready;
    if (chk) check("s_ready", s_ready, exp_ready);
    @(posedge clk);
    #1;
    if (exp_pop) begin
      expd = mq.pop_front();
      macc = expd;
      mcnt = mcnt + 16'd1;
    end
    if (exp_push) mq.push_back(d);
    if (fl) mq.delete();
    if (acc_ce === 1'b1) pulses++;
    if (chk) begin
      check("acc_ce", acc_ce, exp_pop);
      check("acc_in", acc_in, macc);
      check("level", level, mq.size());
      check("issued_cnt", issued_cnt, mcnt);
    end
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    pulses  = 0;
    fl      = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    hold    = 1'b0;
    rst     = 1'b0;
    model_reset();
    #2;
    check("init_level", level, 3'd0);
    check("init_acc_ce", acc_ce, 1'b0);
    check("init_s_ready", s_ready, 1'b1);
    rst = 1'b1;

    // Single sample latency
    cyc(1'b1, 8'h11, 1'b0, 1'b1);
    check("lat_edge1_ce", acc_ce, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("lat_edge2_ce", acc_ce, 1'b1);
    check("lat_edge2_data", acc_in, 8'h11);
    check("lat_edge2_level", level, 3'd0);

    // Fill under hold, overflow rejected, then drain in order
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i), 1'b1, 1'b1);
    check("full_level", level, 3'd4);
    check("full_ready", s_ready, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      check("drain_data", acc_in, 32'(i));
      check("drain_ce", acc_ce, 1'b1);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("drain_empty_ce", acc_ce, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);

    // Continuous stream
    do_reset();
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b1);
      check("stream_level_le1", 32'(level <= 3'd1), 32'd1);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("stream_pulses", pulses, 16);
    check("stream_issued", issued_cnt, 16'd16);
    check("stream_last", acc_in, 8'h0F);

    // Mid-operation reset discards buffered data
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("pre_rst_ce", acc_ce, 1'b1);
    #2;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("post_rst_no_stale", pulses, 0);

`ifdef ACC_FEEDER_FLUSH_EN
    // Flush overrides push and pop
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b1);
    check("pre_flush_level", level, 3'd3);
    fl = 1'b1;
    cyc(1'b1, 8'hEE, 1'b0, 1'b1);
    check("flush_level", level, 3'd0);
    check("flush_ce", acc_ce, 1'b0);
    fl = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("flush_not_stored", acc_ce, 1'b0);
`endif

    // Counter wrap after 65535 + 1 pops
    do_reset();
    for (int i = 0; i < 65535; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("cnt_ffff", issued_cnt, 16'hFFFF);
    cyc(1'b1, 8'h5A, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("cnt_wrap", issued_cnt, 16'h0000);
    check("cnt_wrap_data", acc_in, 8'h5A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
